// File: rtl/adc_readout_pkg.sv
// Shared constants for the ADC readout path: lane geometry, header nibble and
// the one-hot drain-FSM state encodings used by adc_serial_deframer.
package adc_readout_pkg;

  localparam int NUM_ADC_BITS = 12;
  localparam int NUM_LANES    = 20;
  localparam int LANE_IDX_W   = 5;
  localparam int BIT_CNT_W    = $clog2(NUM_ADC_BITS);

  localparam logic [3:0] HDR_NIBBLE = 4'hA;

  localparam int DRAIN_W = 3;
  typedef logic [DRAIN_W-1:0] drain_state_t;

  localparam drain_state_t S_IDLE = drain_state_t'(32'b1 << 0);
  localparam drain_state_t S_HDR  = drain_state_t'(32'b1 << 1);
  localparam drain_state_t S_DATA = drain_state_t'(32'b1 << 2);

  function automatic logic [15:0] row_header(input logic [8:0] row);
    return {HDR_NIBBLE, 3'b000, row};
  endfunction

endpackage

// File: rtl/adc_lane_shifter.sv
// One serial lane: MSB-first shift register plus the hold register that the
// drain side reads from. Strobe, completion and hold-load gating are shared.
module adc_lane_shifter
  import adc_readout_pkg::*;
#(
  parameter int W = NUM_ADC_BITS
) (
  input  logic         TX_CLK,
  input  logic         rst,
  input  logic         strobe,
  input  logic         complete,
  input  logic         load_hold,
  input  logic         din,
  output logic [W-1:0] hold
);

  logic [W-1:0] shreg;

  // The hold copy takes the final bit directly so it lands on the completing strobe
  always_ff @(posedge TX_CLK) begin
    if (rst) begin
      shreg <= '0;
      hold  <= '0;
    end else begin
      if (strobe) begin
        shreg <= {shreg[W-2:0], din};
      end
      if (complete && load_hold) begin
        hold <= {shreg[W-2:0], din};
      end
    end
  end

endmodule

// File: rtl/adc_serial_deframer.sv
// Rebuilds MSB-first serial ADC samples per lane and drains them as 16-bit
// stream words. Optional row header word enabled by ADC_DESER_ROW_HEADER_EN.
module adc_serial_deframer
  import adc_readout_pkg::*;
(
  input  logic                 TX_CLK,
  input  logic                 rst,
  input  logic                 ro_busy,
  input  logic                 ADC_DATA_VALID,
  input  logic [8:0]           ROWADD,
  input  logic [NUM_LANES-1:0] DOUT,
  output logic [15:0]          out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 overrun
);

  localparam logic [BIT_CNT_W-1:0]  LAST_BIT  = BIT_CNT_W'(NUM_ADC_BITS - 1);
  localparam logic [LANE_IDX_W-1:0] LAST_LANE = LANE_IDX_W'(NUM_LANES - 1);

  logic                    dv_q;
  logic                    dv_q2;
  logic [NUM_LANES-1:0]    dout_q;
  logic [BIT_CNT_W-1:0]    bit_cnt;
  logic                    hold_full;
  logic                    strobe;
  logic                    complete;
  logic                    load_ok;
  logic                    handshake;
  logic                    drain_done;
  logic [NUM_ADC_BITS-1:0] hold [NUM_LANES];

  drain_state_t            state;
  drain_state_t            state_nxt;
  logic [LANE_IDX_W-1:0]   lane;
  logic [LANE_IDX_W-1:0]   lane_nxt;
  logic [15:0]             data_nxt;
  logic                    valid_nxt;
  logic                    last_nxt;

  // Input capture register and strobe-edge history
  always_ff @(posedge TX_CLK) begin
    if (rst) begin
      dv_q   <= 1'b0;
      dv_q2  <= 1'b0;
      dout_q <= '0;
    end else begin
      dv_q   <= ADC_DATA_VALID;
      dv_q2  <= dv_q;
      dout_q <= DOUT;
    end
  end

  // ro_busy low masks the strobe so an abort always wins over a bit
  assign strobe     = dv_q & ~dv_q2 & ro_busy;
  assign complete   = strobe & (bit_cnt == LAST_BIT);
  assign handshake  = out_valid & out_ready;
  assign drain_done = (state == S_DATA) & handshake & (lane == LAST_LANE);
  assign load_ok    = ~hold_full | drain_done;

  // Bit counter: cleared by abort, wraps on word completion
  always_ff @(posedge TX_CLK) begin
    if (rst) begin
      bit_cnt <= '0;
    end else if (!ro_busy) begin
      bit_cnt <= '0;
    end else if (complete) begin
      bit_cnt <= '0;
    end else if (strobe) begin
      bit_cnt <= bit_cnt + BIT_CNT_W'(1);
    end else begin
      bit_cnt <= bit_cnt;
    end
  end

  // Hold occupancy and sticky overrun
  always_ff @(posedge TX_CLK) begin
    if (rst) begin
      hold_full <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (complete && load_ok) begin
        hold_full <= 1'b1;
      end else if (drain_done) begin
        hold_full <= 1'b0;
      end
      if (complete && !load_ok) begin
        overrun <= 1'b1;
      end
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    adc_lane_shifter #(
      .W (NUM_ADC_BITS)
    ) u_lane (
      .TX_CLK    (TX_CLK),
      .rst       (rst),
      .strobe    (strobe),
      .complete  (complete),
      .load_hold (load_ok),
      .din       (dout_q[l]),
      .hold      (hold[l])
    );
  end

`ifdef ADC_DESER_ROW_HEADER_EN
  logic [8:0] row_tag;
  logic [8:0] hold_row;

  // Row tag follows the first bit of a word and travels with the held word
  always_ff @(posedge TX_CLK) begin
    if (rst) begin
      row_tag  <= 9'd0;
      hold_row <= 9'd0;
    end else begin
      if (strobe && (bit_cnt == BIT_CNT_W'(0))) begin
        row_tag <= ROWADD;
      end
      if (complete && load_ok) begin
        hold_row <= row_tag;
      end
    end
  end
`else
  logic rowadd_unused;
  assign rowadd_unused = ^ROWADD;
`endif

  // Drain FSM state register
  always_ff @(posedge TX_CLK) begin
    if (rst) begin
      state <= S_IDLE;
      lane  <= '0;
    end else begin
      state <= state_nxt;
      lane  <= lane_nxt;
    end
  end

  // Drain FSM next-state logic
  always_comb begin
    state_nxt = state;
    lane_nxt  = lane;
    case (state)
      S_IDLE: begin
        if (hold_full) begin
`ifdef ADC_DESER_ROW_HEADER_EN
          state_nxt = S_HDR;
`else
          state_nxt = S_DATA;
`endif
          lane_nxt  = '0;
        end else begin
          state_nxt = S_IDLE;
        end
      end
`ifdef ADC_DESER_ROW_HEADER_EN
      S_HDR: begin
        if (handshake) begin
          state_nxt = S_DATA;
        end else begin
          state_nxt = S_HDR;
        end
      end
`endif
      S_DATA: begin
        if (handshake && (lane == LAST_LANE)) begin
          state_nxt = S_IDLE;
          lane_nxt  = '0;
        end else if (handshake) begin
          lane_nxt  = lane + LANE_IDX_W'(1);
        end else begin
          lane_nxt  = lane;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        lane_nxt  = '0;
      end
    endcase
  end

  // Output values for the next cycle; recomputing from held state keeps them stable under stall
  always_comb begin
    valid_nxt = (state_nxt != S_IDLE);
    data_nxt  = 16'h0000;
    last_nxt  = 1'b0;
    case (state_nxt)
      S_DATA: begin
        last_nxt = (lane_nxt == LAST_LANE);
        if (lane_nxt <= LAST_LANE) begin
          data_nxt = 16'(hold[lane_nxt]);
        end else begin
          data_nxt = 16'h0000;
        end
      end
`ifdef ADC_DESER_ROW_HEADER_EN
      S_HDR: begin
        data_nxt = row_header(hold_row);
      end
`endif
      default: begin
        data_nxt = 16'h0000;
        last_nxt = 1'b0;
      end
    endcase
  end

  // Registered stream outputs
  always_ff @(posedge TX_CLK) begin
    if (rst) begin
      out_data  <= 16'h0000;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      out_data  <= data_nxt;
      out_valid <= valid_nxt;
      out_last  <= last_nxt;
    end
  end

endmodule

// File: tb/tb_adc_serial_deframer.sv
// Scoreboard bench for adc_serial_deframer: stimulus pushes expected words,
// a monitor branch pops and compares on every accepted output word.
`timescale 1ns/1ps
module tb_adc_serial_deframer;

  logic        TX_CLK = 1'b0;
  logic        rst;
  logic        ro_busy;
  logic        ADC_DATA_VALID;
  logic [8:0]  ROWADD;
  logic [19:0] DOUT;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        overrun;

  int          total = 0;
  int          bad   = 0;
  logic [16:0] sb [$];
  logic [11:0] words [20];
  logic        mon_stalled = 1'b0;
  logic [16:0] mon_prev = 17'd0;
  logic [16:0] exp_word;

  always #5 TX_CLK = ~TX_CLK;

  adc_serial_deframer dut (
    .TX_CLK         (TX_CLK),
    .rst            (rst),
    .ro_busy        (ro_busy),
    .ADC_DATA_VALID (ADC_DATA_VALID),
    .ROWADD         (ROWADD),
    .DOUT           (DOUT),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_last       (out_last),
    .overrun        (overrun)
  );

  task automatic tick();
    @(posedge TX_CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Lane 0 carries the directed word, other lanes get distinct derived words
  task automatic make_row(input logic [11:0] lane0, input int seed);
    words[0] = lane0;
    for (int l = 1; l < 20; l++) words[l] = lane0 ^ 12'((l * seed) & 12'hFFF);
  endtask

  task automatic push_row(input logic [8:0] row);
`ifdef ADC_DESER_ROW_HEADER_EN
    sb.push_back({1'b0, 4'hA, 3'b000, row});
`endif
    for (int l = 0; l < 20; l++) sb.push_back({(l == 19) ? 1'b1 : 1'b0, 4'h0, words[l]});
  endtask

  task automatic send_bits(input int from, input int upto, input int hold);
    for (int b = from; b <= upto; b++) begin
      for (int l = 0; l < 20; l++) DOUT[l] = words[l][11-b];
      ADC_DATA_VALID = 1'b1;
      repeat (hold) tick();
      ADC_DATA_VALID = 1'b0;
      repeat (2) tick();
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < 2000) begin
      tick();
      n++;
    end
    check(name, 32'(n < 2000), 32'd1);
  endtask

  initial begin
    fork
      begin : stim
        int n;
        rst = 1'b1; ro_busy = 1'b0; ADC_DATA_VALID = 1'b0; ROWADD = 9'd0;
        DOUT = 20'd0; out_ready = 1'b1;
        repeat (3) tick();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        rst = 1'b0; ro_busy = 1'b1;
        tick();

        // 1: single-cycle strobes, lane0 = 1010_1100_0011
        make_row(12'hAC3, 37); ROWADD = 9'd5; push_row(9'd5);
        check("s1_lane0_vec", 32'(sb[0] & 17'hFFFF), 32'(16'h0AC3) | 32'(sb[0] & 17'hF000));
        send_bits(0, 11, 1); wait_drain("s1_drain");
        check("s1_overrun", 32'(overrun), 32'd0);

        // 2: strobe level held 4 cycles per bit
        ROWADD = 9'd5; push_row(9'd5);
        send_bits(0, 11, 4); wait_drain("s2_drain");

        // 3: 30-cycle stall during drain while next row partly captures
        out_ready = 1'b0;
        make_row(12'h35C, 7); ROWADD = 9'd9; push_row(9'd9);
        send_bits(0, 11, 1);
        n = 0;
        while (!out_valid && n < 50) begin tick(); n++; end
        check("s3_valid_seen", 32'(out_valid), 32'd1);
        make_row(12'h6B2, 19); ROWADD = 9'd10; push_row(9'd10);
        send_bits(0, 5, 1);
        repeat (12) tick();
        out_ready = 1'b1;
        n = 0;
        while (sb.size() > 20 && n < 200) begin tick(); n++; end
        check("s3_first_row", 32'(n < 200), 32'd1);
        send_bits(6, 11, 1); wait_drain("s3_drain");
        check("s3_overrun", 32'(overrun), 32'd0);

        // 4: two rows complete under back-pressure, second dropped
        out_ready = 1'b0;
        make_row(12'hF0F, 3); ROWADD = 9'd12; push_row(9'd12);
        send_bits(0, 11, 1);
        make_row(12'h123, 5); ROWADD = 9'd13;
        send_bits(0, 11, 1);
        repeat (2) tick();
        check("s4_overrun_set", 32'(overrun), 32'd1);
        out_ready = 1'b1; wait_drain("s4_drain");
        check("s4_overrun_sticky", 32'(overrun), 32'd1);
        rst = 1'b1; tick(); rst = 1'b0; tick();
        check("s4_overrun_clr", 32'(overrun), 32'd0);

        // 5: abort after 7 strobes, then a fresh word
        make_row(12'hFFF, 1); ROWADD = 9'd20;
        send_bits(0, 6, 1);
        ro_busy = 1'b0; repeat (2) tick(); ro_busy = 1'b1;
        make_row(12'h5A6, 11); ROWADD = 9'd21; push_row(9'd21);
        send_bits(0, 11, 1); wait_drain("s5_drain");

        // 6: reset while lane 9 is presented
        make_row(12'h9E1, 13); ROWADD = 9'd30; push_row(9'd30);
        send_bits(0, 11, 1);
        n = 0;
        while (sb.size() > 11 && n < 500) begin tick(); n++; end
        check("s6_reach_lane9", 32'(n < 500), 32'd1);
        out_ready = 1'b0; rst = 1'b1;
        tick();
        check("s6_valid_drop", 32'(out_valid), 32'd0);
        check("s6_overrun", 32'(overrun), 32'd0);
        sb.delete();
        rst = 1'b0; out_ready = 1'b1;
        tick();
        make_row(12'h0F0, 17); ROWADD = 9'd31; push_row(9'd31);
        send_bits(0, 11, 1); wait_drain("s6_drain");
        repeat (3) tick();
      end
      begin : monitor
        forever begin
          @(negedge TX_CLK);
          if (out_valid && mon_stalled) check("stall_stable", 32'({out_last, out_data}), 32'(mon_prev));
          mon_stalled = out_valid && !out_ready;
          mon_prev = {out_last, out_data};
          if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
              total++; bad++;
              $display("FAIL unexpected_word: got %0h expected none", {out_last, out_data});
            end else begin
              exp_word = sb.pop_front();
              check("word", 32'({out_last, out_data}), 32'(exp_word));
            end
          end
        end
      end
    join_any
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
